// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: channel-state encoding
// and the select-width helper.
package demux_pkg;

    localparam logic CH_EMPTY = 1'b0;
    localparam logic CH_FULL  = 1'b1;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux1ton_stream_if.sv
// Producer-side and consumer-side handshake bundle for demux1ton_stream.
interface demux1ton_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    import demux_pkg::*;

    localparam int unsigned SEL_W = sel_width(N);

    logic [WIDTH-1:0]   data_in;
    logic [SEL_W-1:0]   sel;
    logic               bcast;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic               err;

    modport slave (
        input  data_in, sel, bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err
    );

    modport master (
        output data_in, sel, bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err
    );

endinterface

// File: rtl/demux_chan_reg.sv
// One-entry output register slice for a single demux channel; supports pop and
// refill on the same edge.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             free
);

    logic             state_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else if (load) begin
            state_q <= CH_FULL;
            data_q  <= d;
        end else if (state_q == CH_FULL && pop) begin
            // Data is left in place; only the occupancy drops.
            state_q <= CH_EMPTY;
        end
    end

    assign q     = data_q;
    assign valid = (state_q == CH_FULL);
    assign free  = (state_q == CH_EMPTY) | pop;

endmodule

// File: rtl/demux1ton_stream.sv
// Registered 1-to-N stream demultiplexer: routes each accepted word to channel sel,
// or to every channel when bcast is set; out-of-range selects are dropped with err.
module demux1ton_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input logic              clk,
    input logic              rst,
    demux1ton_stream_if.slave bus
);

    localparam logic [SEL_W:0] NUM_CH = N[SEL_W:0];

    logic [N-1:0]       free;
    logic [N-1:0]       load;
    logic [N-1:0]       valid_all;
    logic [N*WIDTH-1:0] data_all;
    logic               sel_ok;
    logic               in_ready;
    logic               accept;
    logic               err_q;

    assign sel_ok = ({1'b0, bus.sel} < NUM_CH);

    // Broadcast is all-or-nothing, so every channel must be able to take the word.
    always_comb begin
        in_ready = 1'b1;
        if (bus.bcast) begin
            in_ready = &free;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (bus.sel == SEL_W'(k)) begin
                    in_ready = free[k];
                end
            end
        end
    end

    assign accept = bus.in_valid & in_ready;

    for (genvar k = 0; k < int'(N); k++) begin : g_chan
        assign load[k] = accept & (bus.bcast | (bus.sel == SEL_W'(k)));

        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .d     (bus.data_in),
            .pop   (bus.out_ready[k]),
            .q     (data_all[k*WIDTH +: WIDTH]),
            .valid (valid_all[k]),
            .free  (free[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~bus.bcast & ~sel_ok;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_all;
    assign bus.out_valid = valid_all;
    assign bus.err       = err_q;

endmodule
